// File: rtl/gray_updown_counter.sv
// gray_updown_counter: up/down Gray-code counter built from per-bit toggle cells steered by a parity flop,
// with clear/load, wrap or saturate at the range ends, a binary view and end-of-range flags.
module gray_updown_counter #(
   parameter int               WIDTH      = 4,
   parameter bit               SATURATE   = 1'b0,
   parameter logic [WIDTH-1:0] RESET_GRAY = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_gray,
   input  logic             enable,
   input  logic             up_n_dn,
   output logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin,
   output logic             parity,
   output logic             at_max,
   output logic             at_min,
   output logic             wrap
);
   logic [WIDTH-1:0] gray_q, gray_d, tog, zero_below;
   logic             parity_q, parity_d, wrap_q, wrap_d, sel, at_edge;

   assign gray   = gray_q;
   assign parity = parity_q;
   assign wrap   = wrap_q;
   assign at_max = gray_q == {1'b1, {(WIDTH-1){1'b0}}};
   assign at_min = gray_q == '0;

   always_comb begin
      bin[WIDTH-1] = gray_q[WIDTH-1];
      for (int k = WIDTH-2; k >= 0; k--) bin[k] = bin[k+1] ^ gray_q[k];
   end

   // Bit 0 toggles on odd-parity-relative steps; otherwise the cell above the lowest set bit toggles.
   always_comb begin
      sel           = up_n_dn ^ parity_q;
      zero_below[0] = 1'b1;
      for (int k = 1; k < WIDTH; k++) zero_below[k] = zero_below[k-1] & ~gray_q[k-1];
      tog    = '0;
      tog[0] = sel;
      for (int k = 1; k < WIDTH-1; k++) tog[k] = ~sel & gray_q[k-1] & zero_below[k-1];
      tog[WIDTH-1] = ~sel & (gray_q[WIDTH-1] | gray_q[WIDTH-2]) & zero_below[WIDTH-2];
      if (at_min && !up_n_dn) tog = {1'b1, {(WIDTH-1){1'b0}}};
      at_edge  = up_n_dn ? at_max : at_min;
      gray_d   = gray_q;
      parity_d = parity_q;
      wrap_d   = 1'b0;
      if (clr) begin
         gray_d   = '0;
         parity_d = 1'b0;
      end else if (load) begin
         gray_d   = load_gray;
         parity_d = ^load_gray;
      end else if (enable) begin
         wrap_d = at_edge;
         if (!(SATURATE && at_edge)) begin
            gray_d   = gray_q ^ tog;
            parity_d = ~parity_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gray_q   <= RESET_GRAY;
         parity_q <= ^RESET_GRAY;
         wrap_q   <= 1'b0;
      end else begin
         gray_q   <= gray_d;
         parity_q <= parity_d;
         wrap_q   <= wrap_d;
      end
   end
endmodule
